// File: rtl/fetch_unit.sv
// RV32 instruction fetch stage.
// Owns the program counter, fetches one word at a time over a req/gnt/rvalid
// handshake and presents the instruction with its PC to decode through
// valid/ready. Branch/jump redirects from execute replace the PC. A redirect
// while a request is outstanding marks that response as stale so it is dropped.
// A misaligned redirect target parks the unit in a sticky fault state.
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,

    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,

    output logic [31:0] instr_out,
    output logic [31:0] pc_out,
    output logic [31:0] pc_plus4_out,
    output logic        instr_valid,
    input  logic        instr_ready,

    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        misaligned_fault
);

    typedef enum logic [1:0] {
        ST_REQ,
        ST_WAIT,
        ST_HOLD,
        ST_FAULT
    } state_t;

    state_t      state, state_next;
    logic [31:0] pc, pc_next;
    logic        drop, drop_next;
    logic [31:0] instr_q, instr_next;
    logic [31:0] pc_out_q, pc_out_next;
    logic        valid_q, valid_next;
    logic        fault_q, fault_next;

    logic redirect_live;
    logic redirect_misaligned;

    // A redirect has no effect once the unit is faulted; only reset leaves FAULT.
    assign redirect_live       = redirect_valid && (state != ST_FAULT);
    assign redirect_misaligned = redirect_pc[1:0] != 2'b00;

    // Next-state and next-datapath selection for the fetch FSM.
    // NOTE: every variable gets its hold value first, so no path can infer a latch.
    always_comb begin
        state_next  = state;
        pc_next     = pc;
        drop_next   = drop;
        instr_next  = instr_q;
        pc_out_next = pc_out_q;
        valid_next  = valid_q;
        fault_next  = fault_q;

        case (state)
            ST_REQ: begin
                if (redirect_live) begin
                    // The old request is withdrawn; if it was granted anyway,
                    // its response must be discarded.
                    pc_next = redirect_pc;
                    if (imem_gnt) begin
                        drop_next  = 1'b1;
                        state_next = ST_WAIT;
                    end
                end else if (imem_gnt) begin
                    state_next = ST_WAIT;
                end
            end

            ST_WAIT: begin
                if (redirect_live) begin
                    pc_next = redirect_pc;
                    if (imem_rvalid) begin
                        // Response arriving with the redirect is the stale one.
                        drop_next  = 1'b0;
                        state_next = ST_REQ;
                    end else begin
                        drop_next = 1'b1;
                    end
                end else if (imem_rvalid) begin
                    if (drop) begin
                        drop_next  = 1'b0;
                        state_next = ST_REQ;
                    end else begin
                        instr_next  = imem_rdata;
                        pc_out_next = pc;
                        valid_next  = 1'b1;
                        state_next  = ST_HOLD;
                    end
                end
            end

            ST_HOLD: begin
                // Redirect takes priority over a transfer in the same cycle.
                if (redirect_live) begin
                    pc_next    = redirect_pc;
                    state_next = ST_REQ;
                end else if (instr_ready) begin
                    pc_next    = pc + 32'd4;
                    valid_next = 1'b0;
                    instr_next = NOP_INSTR;
                    state_next = ST_REQ;
                end
            end

            default: begin
                // ST_FAULT: stay parked until reset.
            end
        endcase

        if (redirect_live) begin
            valid_next = 1'b0;
            instr_next = NOP_INSTR;
            if (redirect_misaligned) begin
                // Any outstanding response is ignored because FAULT never looks at rvalid.
                fault_next = 1'b1;
                drop_next  = 1'b0;
                state_next = ST_FAULT;
            end
        end
    end

    // State and datapath registers with synchronous reset.
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_REQ;
            pc       <= RESET_PC;
            drop     <= 1'b0;
            instr_q  <= NOP_INSTR;
            pc_out_q <= RESET_PC;
            valid_q  <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            state    <= state_next;
            pc       <= pc_next;
            drop     <= drop_next;
            instr_q  <= instr_next;
            pc_out_q <= pc_out_next;
            valid_q  <= valid_next;
            fault_q  <= fault_next;
        end
    end

    assign imem_req         = (state == ST_REQ);
    assign imem_addr        = pc;
    assign instr_out        = instr_q;
    assign pc_out           = pc_out_q;
    assign pc_plus4_out     = pc_out_q + 32'd4;
    assign instr_valid      = valid_q;
    assign misaligned_fault = fault_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed, table-driven bench for fetch_unit. Each table row gives the
// outputs expected during a cycle and the inputs driven for that cycle's edge.
module tb_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] instr_out;
    logic [31:0] pc_out;
    logic [31:0] pc_plus4_out;
    logic        instr_valid;
    logic        instr_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        misaligned_fault;

    int checks = 0;
    int errors = 0;

    typedef struct {
        // inputs for this cycle
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
        logic        ready;
        logic        rdv;
        logic [31:0] rdpc;
        // outputs expected during this cycle
        logic        req;
        logic [31:0] addr;
        logic        valid;
        logic [31:0] instr;
        logic [31:0] pco;
        logic [31:0] pc4;
        logic        fault;
    } vec_t;

    vec_t tbl[$];

    fetch_unit dut (
        .clk              (clk),
        .reset            (reset),
        .imem_req         (imem_req),
        .imem_addr        (imem_addr),
        .imem_gnt         (imem_gnt),
        .imem_rvalid      (imem_rvalid),
        .imem_rdata       (imem_rdata),
        .instr_out        (instr_out),
        .pc_out           (pc_out),
        .pc_plus4_out     (pc_plus4_out),
        .instr_valid      (instr_valid),
        .instr_ready      (instr_ready),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .misaligned_fault (misaligned_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Full output check; pc_out/pc_plus4_out only matter when an instruction is valid.
    task automatic check_outs(input string tag, input vec_t v);
        check({tag, " imem_req"},   {31'd0, imem_req},         {31'd0, v.req});
        check({tag, " imem_addr"},  imem_addr,                 v.addr);
        check({tag, " valid"},      {31'd0, instr_valid},      {31'd0, v.valid});
        check({tag, " instr_out"},  instr_out,                 v.instr);
        check({tag, " fault"},      {31'd0, misaligned_fault}, {31'd0, v.fault});
        if (v.valid) begin
            check({tag, " pc_out"},       pc_out,       v.pco);
            check({tag, " pc_plus4_out"}, pc_plus4_out, v.pc4);
        end
    endtask

    task automatic drive(input logic gnt, input logic rvalid, input logic [31:0] rdata,
                         input logic ready, input logic rdv, input logic [31:0] rdpc);
        imem_gnt       = gnt;
        imem_rvalid    = rvalid;
        imem_rdata     = rdata;
        instr_ready    = ready;
        redirect_valid = rdv;
        redirect_pc    = rdpc;
    endtask

    function automatic vec_t mk(input logic gnt, input logic rvalid, input logic [31:0] rdata,
                                input logic ready, input logic rdv, input logic [31:0] rdpc,
                                input logic req, input logic [31:0] addr, input logic valid,
                                input logic [31:0] instr, input logic [31:0] pco,
                                input logic [31:0] pc4, input logic fault);
        vec_t v;
        v.gnt = gnt; v.rvalid = rvalid; v.rdata = rdata; v.ready = ready;
        v.rdv = rdv; v.rdpc = rdpc;
        v.req = req; v.addr = addr; v.valid = valid; v.instr = instr;
        v.pco = pco; v.pc4 = pc4; v.fault = fault;
        return v;
    endfunction

    task automatic do_reset(input int cycles);
        @(negedge clk);
        reset = 1'b1;
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        repeat (cycles) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, " imem_req"},     {31'd0, imem_req},         32'd1);
        check({tag, " imem_addr"},    imem_addr,                 32'h0);
        check({tag, " valid"},        {31'd0, instr_valid},      32'd0);
        check({tag, " instr_out"},    instr_out,                 NOP);
        check({tag, " pc_out"},       pc_out,                    32'h0);
        check({tag, " pc_plus4_out"}, pc_plus4_out,              32'h4);
        check({tag, " fault"},        {31'd0, misaligned_fault}, 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);

        //           gnt rv rdata          rdy rdv rdpc           req addr           v  instr          pco            pc4            f
        tbl.push_back(mk(1, 0, 32'h0,          1, 0, 32'h0,          1, 32'h0000_0000, 0, NOP,           32'h0,         32'h0,         0)); // 0 REQ 0x0
        tbl.push_back(mk(0, 1, 32'h0010_0093, 1, 0, 32'h0,          0, 32'h0000_0000, 0, NOP,           32'h0,         32'h0,         0)); // 1 WAIT
        tbl.push_back(mk(0, 0, 32'h0,          1, 0, 32'h0,          0, 32'h0000_0000, 1, 32'h0010_0093, 32'h0,         32'h4,         0)); // 2 HOLD
        tbl.push_back(mk(1, 0, 32'h0,          1, 0, 32'h0,          1, 32'h0000_0004, 0, NOP,           32'h0,         32'h0,         0)); // 3 REQ 0x4
        tbl.push_back(mk(0, 1, 32'h0020_0113, 1, 0, 32'h0,          0, 32'h0000_0004, 0, NOP,           32'h0,         32'h0,         0));
        tbl.push_back(mk(0, 0, 32'h0,          1, 0, 32'h0,          0, 32'h0000_0004, 1, 32'h0020_0113, 32'h4,         32'h8,         0));
        tbl.push_back(mk(1, 0, 32'h0,          1, 0, 32'h0,          1, 32'h0000_0008, 0, NOP,           32'h0,         32'h0,         0)); // 6 REQ 0x8
        tbl.push_back(mk(0, 1, 32'h0000_0033, 1, 0, 32'h0,          0, 32'h0000_0008, 0, NOP,           32'h0,         32'h0,         0));
        // backpressure: ready low for 5 cycles in HOLD
        for (int i = 0; i < 5; i++)
            tbl.push_back(mk(0, 0, 32'h0,      0, 0, 32'h0,          0, 32'h0000_0008, 1, 32'h0000_0033, 32'h8,         32'hC,         0));
        tbl.push_back(mk(0, 0, 32'h0,          1, 0, 32'h0,          0, 32'h0000_0008, 1, 32'h0000_0033, 32'h8,         32'hC,         0)); // 13 release
        tbl.push_back(mk(0, 0, 32'h0,          1, 0, 32'h0,          1, 32'h0000_000C, 0, NOP,           32'h0,         32'h0,         0)); // 14 no gnt
        tbl.push_back(mk(1, 0, 32'h0,          1, 0, 32'h0,          1, 32'h0000_000C, 0, NOP,           32'h0,         32'h0,         0)); // 15 addr stable
        tbl.push_back(mk(0, 1, 32'h0040_0213, 1, 0, 32'h0,          0, 32'h0000_000C, 0, NOP,           32'h0,         32'h0,         0));
        tbl.push_back(mk(0, 0, 32'h0,          1, 0, 32'h0,          0, 32'h0000_000C, 1, 32'h0040_0213, 32'hC,         32'h10,        0));
        tbl.push_back(mk(1, 0, 32'h0,          1, 0, 32'h0,          1, 32'h0000_0010, 0, NOP,           32'h0,         32'h0,         0)); // 18 REQ 0x10
        tbl.push_back(mk(0, 0, 32'h0,          1, 1, 32'h0000_0100, 0, 32'h0000_0010, 0, NOP,           32'h0,         32'h0,         0)); // 19 redirect in WAIT
        tbl.push_back(mk(0, 1, 32'h0000_006F, 1, 0, 32'h0,          0, 32'h0000_0100, 0, NOP,           32'h0,         32'h0,         0)); // 20 stale rvalid
        tbl.push_back(mk(1, 0, 32'h0,          1, 0, 32'h0,          1, 32'h0000_0100, 0, NOP,           32'h0,         32'h0,         0)); // 21 dropped, REQ 0x100
        tbl.push_back(mk(0, 1, 32'h0050_0293, 1, 0, 32'h0,          0, 32'h0000_0100, 0, NOP,           32'h0,         32'h0,         0));
        tbl.push_back(mk(0, 0, 32'h0,          1, 1, 32'h0000_0020, 0, 32'h0000_0100, 1, 32'h0050_0293, 32'h100,       32'h104,       0)); // 23 redirect+xfer
        tbl.push_back(mk(1, 0, 32'h0,          1, 0, 32'h0,          1, 32'h0000_0020, 0, NOP,           32'h0,         32'h0,         0));
        tbl.push_back(mk(0, 1, 32'h0060_0313, 1, 0, 32'h0,          0, 32'h0000_0020, 0, NOP,           32'h0,         32'h0,         0));
        tbl.push_back(mk(0, 0, 32'h0,          1, 1, 32'h0000_0040, 0, 32'h0000_0020, 1, 32'h0060_0313, 32'h20,        32'h24,        0)); // 26 redirect wins
        tbl.push_back(mk(1, 0, 32'h0,          1, 1, 32'h0000_0080, 1, 32'h0000_0040, 0, NOP,           32'h0,         32'h0,         0)); // 27 addr 0x40; redirect+gnt
        tbl.push_back(mk(0, 1, 32'hDEAD_BEEF, 1, 0, 32'h0,          0, 32'h0000_0080, 0, NOP,           32'h0,         32'h0,         0)); // 28 dropped response
        tbl.push_back(mk(0, 0, 32'h0,          1, 1, 32'hFFFF_FFFC, 1, 32'h0000_0080, 0, NOP,           32'h0,         32'h0,         0)); // 29 redirect, no gnt
        tbl.push_back(mk(1, 0, 32'h0,          1, 0, 32'h0,          1, 32'hFFFF_FFFC, 0, NOP,           32'h0,         32'h0,         0));
        tbl.push_back(mk(0, 1, 32'h0070_0393, 1, 0, 32'h0,          0, 32'hFFFF_FFFC, 0, NOP,           32'h0,         32'h0,         0));
        tbl.push_back(mk(0, 0, 32'h0,          1, 0, 32'h0,          0, 32'hFFFF_FFFC, 1, 32'h0070_0393, 32'hFFFF_FFFC, 32'h0000_0000, 0)); // 32 wrap
        tbl.push_back(mk(1, 0, 32'h0,          1, 0, 32'h0,          1, 32'h0000_0000, 0, NOP,           32'h0,         32'h0,         0)); // 33 wrapped to 0
        tbl.push_back(mk(0, 1, 32'h0000_006F, 1, 1, 32'h0000_0200, 0, 32'h0000_0000, 0, NOP,           32'h0,         32'h0,         0)); // 34 redirect+rvalid
        tbl.push_back(mk(1, 0, 32'h0,          1, 0, 32'h0,          1, 32'h0000_0200, 0, NOP,           32'h0,         32'h0,         0));
        tbl.push_back(mk(0, 0, 32'h0,          1, 0, 32'h0,          0, 32'h0000_0200, 0, NOP,           32'h0,         32'h0,         0)); // 36 slow memory
        tbl.push_back(mk(0, 1, 32'h0080_0413, 1, 0, 32'h0,          0, 32'h0000_0200, 0, NOP,           32'h0,         32'h0,         0));
        tbl.push_back(mk(0, 1, 32'hFFFF_FFFF, 0, 0, 32'h0,          0, 32'h0000_0200, 1, 32'h0080_0413, 32'h200,       32'h204,       0)); // 38 rvalid in HOLD ignored
        tbl.push_back(mk(0, 0, 32'h0,          1, 0, 32'h0,          0, 32'h0000_0200, 1, 32'h0080_0413, 32'h200,       32'h204,       0));
        tbl.push_back(mk(1, 0, 32'h0,          1, 0, 32'h0,          1, 32'h0000_0204, 0, NOP,           32'h0,         32'h0,         0));
        tbl.push_back(mk(0, 0, 32'h0,          1, 1, 32'h0000_0102, 0, 32'h0000_0204, 0, NOP,           32'h0,         32'h0,         0)); // 41 misaligned
        tbl.push_back(mk(1, 1, 32'h0000_0073, 1, 0, 32'h0,          0, 32'h0000_0102, 0, NOP,           32'h0,         32'h0,         1)); // 42 FAULT, rvalid ignored
        tbl.push_back(mk(1, 0, 32'h0,          1, 0, 32'h0,          0, 32'h0000_0102, 0, NOP,           32'h0,         32'h0,         1));
        tbl.push_back(mk(0, 0, 32'h0,          1, 0, 32'h0,          0, 32'h0000_0102, 0, NOP,           32'h0,         32'h0,         1));

        // Initial reset
        do_reset(2);
        check_reset_state("reset");

        // Table: check outputs of this cycle, then drive its inputs for the next edge
        for (int i = 0; i < tbl.size(); i++) begin
            check_outs($sformatf("vec%0d", i), tbl[i]);
            drive(tbl[i].gnt, tbl[i].rvalid, tbl[i].rdata, tbl[i].ready, tbl[i].rdv, tbl[i].rdpc);
            @(negedge clk);
        end

        // Reset leaves FAULT and restarts at RESET_PC
        do_reset(1);
        check_reset_state("fault_exit");

        // Reset during WAIT: the rvalid in the cycle after reset must be ignored
        drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        @(negedge clk);
        check("rst_wait req", {31'd0, imem_req}, 32'd0);
        reset = 1'b1;
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        drive(1'b0, 1'b1, 32'h0BAD_0BAD, 1'b1, 1'b0, 32'h0);
        @(negedge clk);
        check("rst_wait late rvalid valid", {31'd0, instr_valid}, 32'd0);
        check("rst_wait late rvalid req",   {31'd0, imem_req},    32'd1);
        check("rst_wait addr",              imem_addr,            32'h0);
        check("rst_wait instr",             instr_out,            NOP);

        // Normal fetch after the abandoned transaction
        drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        @(negedge clk);
        drive(1'b0, 1'b1, 32'h0090_0493, 1'b1, 1'b0, 32'h0);
        @(negedge clk);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        check("post_rst valid",  {31'd0, instr_valid}, 32'd1);
        check("post_rst instr",  instr_out,            32'h0090_0493);
        check("post_rst pc_out", pc_out,               32'h0);
        check("post_rst pc4",    pc_plus4_out,         32'h4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage of the RV32 core. Sits directly upstream of the instruction decoder.
- Owns the program counter and issues word requests to instruction memory over a req/gnt/rvalid handshake.
- Presents the fetched instruction with its PC and PC+4 to decode through a valid/ready handshake.
- Accepts branch/jump redirects from execute and discards stale in-flight responses.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0013, value held on instr_out when no valid instruction is present (addi x0,x0,0).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- imem_req  output  1  request valid to instruction memory.
- imem_addr  output  32  word address of the request; always equals the current pc.
- imem_gnt  input  1  memory accepted the request this cycle.
- imem_rvalid  input  1  read data valid. Arrives at the earliest one cycle after gnt.
- imem_rdata  input  32  instruction word.
- instr_out  output  32  instruction to decode; opcode is instr_out[6:0].
- pc_out  output  32  PC of instr_out.
- pc_plus4_out  output  32  pc_out + 4, mod 2^32.
- instr_valid  output  1  instr_out/pc_out are valid.
- instr_ready  input  1  decode/execute consumes the instruction this cycle.
- redirect_valid  input  1  branch taken or jump; load redirect_pc.
- redirect_pc  input  32  target PC.
- misaligned_fault  output  1  sticky; redirect target not word-aligned.

Behaviour:
- Reset (sampled at clk edge, overrides all other inputs):
  - pc = RESET_PC, state = REQ, drop = 0.
  - instr_valid = 0, instr_out = NOP_INSTR, pc_out = RESET_PC, misaligned_fault = 0.
  - Reset asserted mid-transaction abandons it: drop is cleared, and any rvalid seen in the cycle after reset deasserts is ignored (state is REQ, not WAIT).
- States: REQ, WAIT, HOLD, FAULT. At most one outstanding memory request.
- REQ:
  - imem_req = 1, imem_addr = pc.
  - imem_gnt = 1 -> WAIT. imem_gnt = 0 -> stay in REQ, address stable.
- WAIT:
  - imem_req = 0.
  - imem_rvalid = 1 and drop = 0 -> capture instr_out = imem_rdata, pc_out = pc, set instr_valid, go to HOLD.
  - imem_rvalid = 1 and drop = 1 -> clear drop, go to REQ. Nothing is presented to decode.
- HOLD:
  - instr_valid = 1. instr_out, pc_out and pc_plus4_out are held stable until transfer.
  - instr_valid and instr_ready both 1 -> pc = pc + 4, instr_valid = 0, instr_out = NOP_INSTR, go to REQ.
- Minimum throughput is 3 cycles per instruction (REQ -> WAIT -> HOLD), with gnt in the REQ cycle and rvalid in the following cycle.
- Redirect (redirect_valid = 1, no reset):
  - Redirect wins over a transfer in the same cycle.
  - pc = redirect_pc, instr_valid = 0, instr_out = NOP_INSTR.
  - In REQ: the next cycle requests the new pc. The old request is withdrawn even if gnt arrives in the same cycle; in that case drop = 1 and the state goes to WAIT.
  - In WAIT: drop = 1, stay in WAIT (the stale response is discarded). If rvalid arrives in the same cycle as the redirect, that response is discarded and the state goes to REQ.
  - In HOLD: go to REQ.
- Alignment fault:
  - redirect_pc[1:0] != 0 -> misaligned_fault = 1 (sticky), state = FAULT.
  - FAULT: imem_req = 0, instr_valid = 0. Only reset exits FAULT.
  - If a request is outstanding when the fault occurs, its rvalid is ignored.
- Wrap-around: 32'hFFFF_FFFC + 4 = 32'h0000_0000. No fault is raised.
- imem_rvalid in REQ, HOLD or FAULT is protocol misuse and is ignored.

Test Plan:
- Reset with RESET_PC = 32'h0000_0000; memory grants immediately, rvalid one cycle later; instr_ready held 1 -> addresses 0x0, 0x4, 0x8, one per 3 cycles; pc_plus4_out = 0x4, 0x8, 0xC.
- Backpressure: instr_ready = 0 for 5 cycles in HOLD with rdata 32'h0000_0033 at pc 0x8 -> instr_out and pc_out stable for 5 cycles, imem_req = 0; on release pc advances to 0xC.
- Stale drop: redirect to 0x100 in WAIT for 0x10; rvalid delivers 32'h0000_006F -> not presented, instr_valid stays 0; next request address is 0x100.
- Redirect and transfer in the same cycle in HOLD at pc 0x20, target 0x40 -> next imem_addr = 0x40, not 0x24.
- Redirect to 0x102 -> misaligned_fault = 1, imem_req = 0 permanently; after reset, fault = 0 and the fetch address is RESET_PC.
- pc = 0xFFFF_FFFC, transfer -> next imem_addr = 0x0000_0000, pc_plus4_out was 0x0; reset asserted during WAIT -> subsequent rvalid ignored, first request after reset is at RESET_PC.
